// File: rtl/ex_pkg.sv
// Shared decode/execute definitions: opcodes, funct3/funct7 codes,
// divider FSM states and small combinational helpers.
package ex_pkg;

    // Major opcodes
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_FENCE  = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    // funct7 groups
    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    // ALU funct3
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // Branch funct3
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // Divider FSM states
    typedef enum logic [1:0] {
        DIV_IDLE = 2'd0,
        DIV_BUSY = 2'd1,
        DIV_DONE = 2'd2
    } div_state_e;

    // Integer ALU shared by OP and OP-IMM; shifts use only the low five bits
    function automatic logic [31:0] alu_calc(input logic [2:0]  f3,
                                             input logic        alt,
                                             input logic [31:0] a,
                                             input logic [31:0] b);
        logic [31:0] r;
        case (f3)
            F3_ADD:  r = alt ? (a - b) : (a + b);
            F3_SLL:  r = a << b[4:0];
            F3_SLT:  r = {31'b0, $signed(a) < $signed(b)};
            F3_SLTU: r = {31'b0, a < b};
            F3_XOR:  r = a ^ b;
            F3_SR:   r = alt ? 32'($signed(a) >>> b[4:0]) : (a >> b[4:0]);
            F3_OR:   r = a | b;
            default: r = a & b;
        endcase
        return r;
    endfunction

    // Apply operand signs to an unsigned quotient/remainder pair
    function automatic logic [31:0] div_fix(input logic        is_rem,
                                            input logic        neg_q,
                                            input logic        neg_r,
                                            input logic [31:0] quot,
                                            input logic [31:0] rem);
        if (is_rem)
            return neg_r ? -rem : rem;
        else
            return neg_q ? -quot : quot;
    endfunction

endpackage

// File: rtl/ex_div.sv
// Iterative restoring divider for DIV/DIVU/REM/REMU.
// op[0] = unsigned, op[1] = remainder (funct3[1:0]).
// Divide-by-zero and signed overflow go straight from IDLE to DONE.
module ex_div
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        busy,
    output logic        done,
    output logic [31:0] result
);

    div_state_e  state_q;
    logic [4:0]  count_q;
    logic [31:0] dvd_q;
    logic [31:0] dsr_q;
    logic [31:0] rem_q;
    logic        is_rem_q;
    logic        neg_q_q;
    logic        neg_r_q;
    logic [31:0] result_q;

    logic        is_signed;
    logic        neg_a;
    logic        neg_b;
    logic [31:0] abs_a;
    logic [31:0] abs_b;
    logic        div_zero;
    logic        div_ovf;
    logic [32:0] rem_sh;
    logic        fits;
    logic [31:0] rem_nxt;
    logic [31:0] quot_nxt;

    // Operand preparation and one restoring step
    always_comb begin
        is_signed = ~op[0];
        neg_a     = is_signed & dividend[31];
        neg_b     = is_signed & divisor[31];
        abs_a     = neg_a ? -dividend : dividend;
        abs_b     = neg_b ? -divisor : divisor;
        div_zero  = (divisor == 32'h0);
        div_ovf   = is_signed && (dividend == 32'h8000_0000) && (divisor == 32'hFFFF_FFFF);
        rem_sh    = {rem_q, dvd_q[31]};
        fits      = (rem_sh >= {1'b0, dsr_q});
        // Partial remainder stays below the divisor, so 32-bit wrap is exact
        rem_nxt   = fits ? (rem_sh[31:0] - dsr_q) : rem_sh[31:0];
        quot_nxt  = {dvd_q[30:0], fits};
    end

    // Divider FSM: latch operands, iterate 32 steps, present result one cycle
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (rst) begin
            state_q  <= DIV_IDLE;
            count_q  <= 5'd0;
            dvd_q    <= 32'h0;
            dsr_q    <= 32'h0;
            rem_q    <= 32'h0;
            is_rem_q <= 1'b0;
            neg_q_q  <= 1'b0;
            neg_r_q  <= 1'b0;
            result_q <= 32'h0;
        end else begin
            case (state_q)
                DIV_IDLE: begin
                    if (start) begin
                        is_rem_q <= op[1];
                        dvd_q    <= abs_a;
                        dsr_q    <= abs_b;
                        rem_q    <= 32'h0;
                        count_q  <= 5'd0;
                        neg_q_q  <= neg_a ^ neg_b;
                        neg_r_q  <= neg_a;
                        if (div_zero) begin
                            result_q <= op[1] ? dividend : 32'hFFFF_FFFF;
                            state_q  <= DIV_DONE;
                        end else if (div_ovf) begin
                            result_q <= op[1] ? 32'h0 : 32'h8000_0000;
                            state_q  <= DIV_DONE;
                        end else begin
                            state_q  <= DIV_BUSY;
                        end
                    end
                end
                DIV_BUSY: begin
                    dvd_q   <= quot_nxt;
                    rem_q   <= rem_nxt;
                    count_q <= count_q + 5'd1;
                    if (count_q == 5'd31) begin
                        result_q <= div_fix(is_rem_q, neg_q_q, neg_r_q, quot_nxt, rem_nxt);
                        state_q  <= DIV_DONE;
                    end
                end
                default: begin
                    state_q <= DIV_IDLE;
                end
            endcase
        end
    end

    assign busy   = (state_q == DIV_BUSY);
    assign done   = (state_q == DIV_DONE);
    assign result = result_q;

endmodule

// File: rtl/ex.sv
// Execute stage: single-cycle ALU, jumps and branches, plus the iterative
// divider. Optional macro EX_MUL_EN adds single-cycle MUL/MULH/MULHSU/MULHU.
module ex
    import ex_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] inst_i,
    input  logic [31:0] inst_addr_i,
    input  logic [31:0] rs1_data_i,
    input  logic [31:0] rs2_data_i,
    input  logic [4:0]  rd_addr_i,
    input  logic        rd_wen_i,
    output logic [31:0] rd_data_o,
    output logic [4:0]  rd_addr_o,
    output logic        rd_wen_o,
    output logic        jump_en_o,
    output logic [31:0] jump_addr_o,
    output logic        hold_flag_o
);

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    logic [31:0] alu_data;
    logic        cls_wen;
    logic        taken;
    logic        br_jump;
    logic [31:0] br_addr;
    logic        is_div;

    logic        div_start;
    logic        div_busy;
    logic        div_done;
    logic [31:0] div_result;

`ifdef EX_MUL_EN
    logic signed [32:0] mul_a;
    logic signed [32:0] mul_b;
    logic signed [63:0] mul_p;
`endif

    assign opcode = inst_i[6:0];
    assign funct3 = inst_i[14:12];
    assign funct7 = inst_i[31:25];
    assign imm_i  = {{20{inst_i[31]}}, inst_i[31:20]};
    assign imm_b  = {{19{inst_i[31]}}, inst_i[31], inst_i[7], inst_i[30:25], inst_i[11:8], 1'b0};
    assign imm_u  = {inst_i[31:12], 12'h0};
    assign imm_j  = {{11{inst_i[31]}}, inst_i[31], inst_i[19:12], inst_i[20], inst_i[30:21], 1'b0};

    // Decode and single-cycle datapath
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // through the case statements can infer a latch.
        alu_data = 32'h0;
        cls_wen  = 1'b0;
        taken    = 1'b0;
        br_jump  = 1'b0;
        br_addr  = 32'h0;
        is_div   = 1'b0;
`ifdef EX_MUL_EN
        mul_a    = 33'sd0;
        mul_b    = 33'sd0;
        mul_p    = 64'sd0;
`endif
        case (opcode)
            OPC_OP_IMM: begin
                alu_data = alu_calc(funct3, (funct3 == F3_SR) && funct7[5], rs1_data_i, imm_i);
                case (funct3)
                    F3_SLL:  cls_wen = (funct7 == F7_BASE);
                    F3_SR:   cls_wen = (funct7 == F7_BASE) || (funct7 == F7_ALT);
                    default: cls_wen = 1'b1;
                endcase
            end
            OPC_OP: begin
                if ((funct7 == F7_BASE) ||
                    ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR)))) begin
                    alu_data = alu_calc(funct3, funct7[5], rs1_data_i, rs2_data_i);
                    cls_wen  = 1'b1;
                end else if (funct7 == F7_MULDIV) begin
                    if (funct3[2]) begin
                        is_div = 1'b1;
                    end else begin
`ifdef EX_MUL_EN
                        // funct3[1:0]: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
                        mul_a    = {(funct3[1:0] != 2'b11) & rs1_data_i[31], rs1_data_i};
                        mul_b    = {(funct3[1:0] == 2'b01) & rs2_data_i[31], rs2_data_i};
                        mul_p    = mul_a * mul_b;
                        alu_data = (funct3[1:0] == 2'b00) ? mul_p[31:0] : mul_p[63:32];
                        cls_wen  = 1'b1;
`else
                        cls_wen  = 1'b0;
`endif
                    end
                end
            end
            OPC_LUI: begin
                alu_data = imm_u;
                cls_wen  = 1'b1;
            end
            OPC_AUIPC: begin
                alu_data = inst_addr_i + imm_u;
                cls_wen  = 1'b1;
            end
            OPC_JAL: begin
                alu_data = inst_addr_i + 32'd4;
                cls_wen  = 1'b1;
                br_jump  = 1'b1;
                br_addr  = inst_addr_i + imm_j;
            end
            OPC_JALR: begin
                if (funct3 == 3'b000) begin
                    alu_data = inst_addr_i + 32'd4;
                    cls_wen  = 1'b1;
                    br_jump  = 1'b1;
                    br_addr  = (rs1_data_i + imm_i) & ~32'h1;
                end
            end
            OPC_BRANCH: begin
                case (funct3)
                    F3_BEQ:  taken = (rs1_data_i == rs2_data_i);
                    F3_BNE:  taken = (rs1_data_i != rs2_data_i);
                    F3_BLT:  taken = ($signed(rs1_data_i) <  $signed(rs2_data_i));
                    F3_BGE:  taken = ($signed(rs1_data_i) >= $signed(rs2_data_i));
                    F3_BLTU: taken = (rs1_data_i <  rs2_data_i);
                    F3_BGEU: taken = (rs1_data_i >= rs2_data_i);
                    default: taken = 1'b0;
                endcase
                br_jump = taken;
                br_addr = taken ? (inst_addr_i + imm_b) : 32'h0;
            end
            OPC_LOAD, OPC_STORE, OPC_FENCE, OPC_SYSTEM: begin
                cls_wen = 1'b0;
            end
            default: begin
                cls_wen = 1'b0;
            end
        endcase
    end

    // A divide is only launched from IDLE; it stalls upstream from that cycle on
    assign div_start = is_div & ~div_busy & ~div_done;

    ex_div u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .op       (funct3[1:0]),
        .dividend (rs1_data_i),
        .divisor  (rs2_data_i),
        .busy     (div_busy),
        .done     (div_done),
        .result   (div_result)
    );

    // Output select: reset forcing, divider phases, then normal single-cycle path
    always_comb begin
        rd_data_o   = 32'h0;
        rd_wen_o    = 1'b0;
        jump_en_o   = 1'b0;
        jump_addr_o = 32'h0;
        hold_flag_o = 1'b0;
        if (rst) begin
            rd_wen_o = 1'b0;
        end else if (div_busy) begin
            hold_flag_o = 1'b1;
        end else if (div_done) begin
            rd_data_o = div_result;
            rd_wen_o  = rd_wen_i && (rd_addr_i != 5'd0);
        end else begin
            rd_data_o   = alu_data;
            rd_wen_o    = rd_wen_i && cls_wen && (rd_addr_i != 5'd0);
            jump_en_o   = br_jump;
            jump_addr_o = br_addr;
            hold_flag_o = div_start;
        end
    end

    assign rd_addr_o = rd_addr_i;

endmodule

// File: tb/tb_ex.sv
// Self-checking bench for ex: directed single-cycle cases, divider timing,
// special divides, reset mid-division and a few model-checked divides.
module tb_ex;

    logic        clk;
    logic        rst;
    logic [31:0] inst_i;
    logic [31:0] inst_addr_i;
    logic [31:0] rs1_data_i;
    logic [31:0] rs2_data_i;
    logic [4:0]  rd_addr_i;
    logic        rd_wen_i;
    logic [31:0] rd_data_o;
    logic [4:0]  rd_addr_o;
    logic        rd_wen_o;
    logic        jump_en_o;
    logic [31:0] jump_addr_o;
    logic        hold_flag_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string       tag;
        logic [31:0] data;
        logic        wen;
        logic        jump;
        logic [31:0] jaddr;
        logic [4:0]  rd;
        logic        hold;
        logic        chk_data;
        logic        chk_jaddr;
    } exp_t;

    exp_t sb[$];

    ex dut (
        .clk         (clk),
        .rst         (rst),
        .inst_i      (inst_i),
        .inst_addr_i (inst_addr_i),
        .rs1_data_i  (rs1_data_i),
        .rs2_data_i  (rs2_data_i),
        .rd_addr_i   (rd_addr_i),
        .rd_wen_i    (rd_wen_i),
        .rd_data_o   (rd_data_o),
        .rd_addr_o   (rd_addr_o),
        .rd_wen_o    (rd_wen_o),
        .jump_en_o   (jump_en_o),
        .jump_addr_o (jump_addr_o),
        .hold_flag_o (hold_flag_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Instruction encoders (register-number fields are irrelevant to ex)
    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
        return {f7, 5'd2, 5'd1, f3, 5'd3, 7'b0110011};
    endfunction
    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [6:0] opc);
        return {imm, 5'd1, f3, 5'd3, opc};
    endfunction
    function automatic logic [31:0] enc_b(input logic [12:0] imm, input logic [2:0] f3);
        return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
    endfunction
    function automatic logic [31:0] enc_u(input logic [19:0] imm, input logic [6:0] opc);
        return {imm, 5'd3, opc};
    endfunction
    function automatic logic [31:0] enc_j(input logic [20:0] imm);
        return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd3, 7'b1101111};
    endfunction

    // Reference divide from language-level arithmetic plus the two special cases
    function automatic logic [31:0] ref_div(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        logic sgn;
        logic rem;
        sgn = ~f3[0];
        rem = f3[1];
        if (b == 32'h0)
            return rem ? a : 32'hFFFF_FFFF;
        if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return rem ? 32'h0 : 32'h8000_0000;
        if (sgn)
            return rem ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
        return rem ? (a % b) : (a / b);
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Pop the oldest expectation and compare it against the outputs now
    task automatic compare_pop();
        exp_t e;
        if (sb.size() == 0) begin
            check("scoreboard empty", 32'(sb.size()), 32'd1);
        end else begin
            e = sb.pop_front();
            check({e.tag, " wen"},   {31'b0, rd_wen_o},    {31'b0, e.wen});
            check({e.tag, " jump"},  {31'b0, jump_en_o},   {31'b0, e.jump});
            check({e.tag, " hold"},  {31'b0, hold_flag_o}, {31'b0, e.hold});
            check({e.tag, " rd"},    {27'b0, rd_addr_o},   {27'b0, e.rd});
            if (e.chk_data)  check({e.tag, " data"},  rd_data_o,   e.data);
            if (e.chk_jaddr) check({e.tag, " jaddr"}, jump_addr_o, e.jaddr);
        end
    endtask

    task automatic single(input string tag, input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] edata, input logic ewen, input logic ejump,
                          input logic [31:0] ejaddr);
        inst_i      = inst;
        inst_addr_i = pc;
        rs1_data_i  = a;
        rs2_data_i  = b;
        rd_addr_i   = rd;
        rd_wen_i    = 1'b1;
        sb.push_back('{tag, edata, ewen, ejump, ejaddr, rd, 1'b0, ewen, ejump});
        @(negedge clk);
        compare_pop();
        @(posedge clk); #1;
    endtask

    task automatic run_div(input string tag, input logic [2:0] f3, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] eres, input int ehold,
                           input bit scramble);
        int hold_cnt;
        int wen_leak;
        bit done_seen;
        hold_cnt  = 0;
        wen_leak  = 0;
        done_seen = 1'b0;
        inst_i      = enc_r(7'b0000001, f3);
        inst_addr_i = 32'h0000_0800;
        rs1_data_i  = a;
        rs2_data_i  = b;
        rd_addr_i   = 5'd9;
        rd_wen_i    = 1'b1;
        sb.push_back('{tag, eres, 1'b1, 1'b0, 32'h0, 5'd9, 1'b0, 1'b1, 1'b0});
        for (int cyc = 0; cyc < 60 && !done_seen; cyc++) begin
            @(negedge clk);
            if (hold_flag_o) begin
                hold_cnt++;
                if (rd_wen_o) wen_leak++;
                if (scramble && hold_cnt == 2) begin
                    rs1_data_i = $urandom;
                    rs2_data_i = $urandom;
                    inst_i     = enc_r(7'b0000001, f3 ^ 3'b010);
                end
                @(posedge clk); #1;
            end else begin
                done_seen = 1'b1;
                compare_pop();
            end
        end
        check({tag, " completed"}, {31'b0, done_seen}, 32'd1);
        if (!done_seen && sb.size() != 0) void'(sb.pop_front());
        check({tag, " hold cycles"}, hold_cnt, ehold);
        check({tag, " no write while held"}, wen_leak, 0);
        @(posedge clk); #1;
        inst_i = 32'h0;
    endtask

    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic [2:0]  rf;
        int          leak;

        // Reset: outputs forced low even though an ADDI is presented
        rst         = 1'b1;
        inst_i      = enc_i(12'h001, 3'b000, 7'b0010011);
        inst_addr_i = 32'h0;
        rs1_data_i  = 32'h7FFF_FFFF;
        rs2_data_i  = 32'h0;
        rd_addr_i   = 5'd5;
        rd_wen_i    = 1'b1;
        sb.push_back('{"reset", 32'h0, 1'b0, 1'b0, 32'h0, 5'd5, 1'b0, 1'b1, 1'b1});
        @(negedge clk);
        compare_pop();
        @(posedge clk); #1;
        rst = 1'b0;

        // Single-cycle classes
        single("addi wrap", enc_i(12'h001, 3'b000, 7'b0010011), 32'h0, 32'h7FFF_FFFF, 32'h0, 5'd5,
               32'h8000_0000, 1'b1, 1'b0, 32'h0);
        single("xori neg imm", enc_i(12'hFFF, 3'b100, 7'b0010011), 32'h0, 32'h0F0F_0F0F, 32'h0, 5'd6,
               32'hF0F0_F0F0, 1'b1, 1'b0, 32'h0);
        single("srli 31", enc_i(12'h01F, 3'b101, 7'b0010011), 32'h0, 32'h8000_0000, 32'h0, 5'd6,
               32'h0000_0001, 1'b1, 1'b0, 32'h0);
        single("srai 4", enc_i(12'h404, 3'b101, 7'b0010011), 32'h0, 32'h8000_0010, 32'h0, 5'd6,
               32'hF800_0001, 1'b1, 1'b0, 32'h0);
        single("slti signed", enc_i(12'hFFF, 3'b010, 7'b0010011), 32'h0, 32'hFFFF_FFFE, 32'h0, 5'd6,
               32'h0000_0001, 1'b1, 1'b0, 32'h0);
        single("sub", enc_r(7'b0100000, 3'b000), 32'h0, 32'd5, 32'd7, 5'd7,
               32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0);
        single("sra low5", enc_r(7'b0100000, 3'b101), 32'h0, 32'h8000_0010, 32'h0000_0024, 5'd7,
               32'hF800_0001, 1'b1, 1'b0, 32'h0);
        single("slt signed", enc_r(7'b0000000, 3'b010), 32'h0, 32'd1, 32'hFFFF_FFFF, 5'd7,
               32'h0, 1'b1, 1'b0, 32'h0);
        single("sltu", enc_r(7'b0000000, 3'b011), 32'h0, 32'd1, 32'hFFFF_FFFF, 5'd7,
               32'h1, 1'b1, 1'b0, 32'h0);
        single("add rd0", enc_r(7'b0000000, 3'b000), 32'h0, 32'd1, 32'd2, 5'd0,
               32'h0, 1'b0, 1'b0, 32'h0);
        single("bad funct7", enc_r(7'b0100000, 3'b100), 32'h0, 32'd1, 32'd2, 5'd7,
               32'h0, 1'b0, 1'b0, 32'h0);
        single("lui", enc_u(20'h12345, 7'b0110111), 32'h0, 32'h0, 32'h0, 5'd8,
               32'h1234_5000, 1'b1, 1'b0, 32'h0);
        single("auipc", enc_u(20'h00001, 7'b0010111), 32'h0000_1000, 32'h0, 32'h0, 5'd8,
               32'h0000_2000, 1'b1, 1'b0, 32'h0);
        single("jal", enc_j(21'h00010), 32'h0000_0200, 32'h0, 32'h0, 5'd1,
               32'h0000_0204, 1'b1, 1'b1, 32'h0000_0210);
        single("jalr", enc_i(12'h004, 3'b000, 7'b1100111), 32'h0000_0050, 32'h0000_0301, 32'h0, 5'd1,
               32'h0000_0054, 1'b1, 1'b1, 32'h0000_0304);
        single("blt taken", enc_b(13'h1FF8, 3'b100), 32'h0000_0100, 32'hFFFF_FFFF, 32'h0, 5'd4,
               32'h0, 1'b0, 1'b1, 32'h0000_00F8);
        single("beq not taken", enc_b(13'h0010, 3'b000), 32'h0000_0100, 32'd3, 32'd4, 5'd4,
               32'h0, 1'b0, 1'b0, 32'h0);
        single("bgeu taken", enc_b(13'h0020, 3'b111), 32'h0000_0400, 32'hFFFF_FFFF, 32'd1, 5'd4,
               32'h0, 1'b0, 1'b1, 32'h0000_0420);
        single("load", enc_i(12'h000, 3'b010, 7'b0000011), 32'h0, 32'h10, 32'h0, 5'd4,
               32'h0, 1'b0, 1'b0, 32'h0);
        single("bubble", 32'h0, 32'h0, 32'h1, 32'h2, 5'd4,
               32'h0, 1'b0, 1'b0, 32'h0);
`ifdef EX_MUL_EN
        single("mulhu", enc_r(7'b0000001, 3'b011), 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10,
               32'hFFFF_FFFE, 1'b1, 1'b0, 32'h0);
`else
        single("mulhu off", enc_r(7'b0000001, 3'b011), 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd10,
               32'h0, 1'b0, 1'b0, 32'h0);
`endif

        // Divider: full iteration and the two short-circuit cases
        run_div("div -7/2",   3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33, 1'b0);
        run_div("rem -7/2",   3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33, 1'b0);
        run_div("divu 9/0",   3'b101, 32'd9, 32'd0, 32'hFFFF_FFFF, 1, 1'b0);
        run_div("remu 9/0",   3'b111, 32'd9, 32'd0, 32'd9, 1, 1'b0);
        run_div("div ovf",    3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1, 1'b0);
        run_div("rem ovf",    3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, 1, 1'b0);

        // Reset pulse at BUSY count 10 abandons the divide
        inst_i      = enc_r(7'b0000001, 3'b101);
        rs1_data_i  = 32'd100;
        rs2_data_i  = 32'd7;
        rd_addr_i   = 5'd9;
        rd_wen_i    = 1'b1;
        repeat (11) @(posedge clk);
        #1;
        rst = 1'b1;
        sb.push_back('{"rst mid div", 32'h0, 1'b0, 1'b0, 32'h0, 5'd9, 1'b0, 1'b1, 1'b1});
        @(negedge clk);
        compare_pop();
        @(posedge clk); #1;
        rst    = 1'b0;
        inst_i = 32'h0;
        sb.push_back('{"post rst", 32'h0, 1'b0, 1'b0, 32'h0, 5'd9, 1'b0, 1'b0, 1'b0});
        @(negedge clk);
        compare_pop();
        leak = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (rd_wen_o || hold_flag_o) leak++;
        end
        check("post rst quiet", leak, 0);
        @(posedge clk); #1;

        // Fresh divide after reset, with inputs disturbed while busy
        run_div("divu 100/7 scrambled", 3'b101, 32'd100, 32'd7, 32'd14, 33, 1'b1);

        // Model-checked divides
        for (int k = 0; k < 3; k++) begin
            ra = $urandom;
            rb = $urandom_range(1, 5000);
            rf = 3'(4 + (k % 4));
            if (k == 1) rb = -rb;
            run_div($sformatf("rand div %0d", k), rf, ra, rb, ref_div(rf, ra, rb), 33, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
